phy_rx_lane: RTL



---
 rtl/phy_rx_lane.sv | 95 +++++++++
 1 files changed

// File: rtl/phy_rx_lane.sv
// phy_rx_lane: serial lane receiver that aligns on the idle char and reassembles 32-bit words
module phy_rx_lane #(
  parameter logic [7:0] IDLE_CHAR   = 8'hBC,
  parameter int         ALIGN_COUNT = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        serial_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active_out,
  output logic        err_out
);
  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;
  state_t      state, state_n;
  logic [7:0]  shift, cur_byte;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [3:0]  idle_cnt, idle_cnt_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic [23:0] word, word_n;
  logic [31:0] data_n;
  logic        valid_n, active_n, err_n, byte_done, is_idle;
  assign cur_byte  = {shift[6:0], serial_in};
  assign byte_done = bit_cnt == 3'd7;
  assign is_idle   = cur_byte == IDLE_CHAR;
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state      <= SEARCH;
      shift      <= '0;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      byte_idx   <= '0;
      word       <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      active_out <= 1'b0;
      err_out    <= 1'b0;
    end else begin
      state      <= state_n;
      shift      <= cur_byte;
      bit_cnt    <= bit_cnt_n;
      idle_cnt   <= idle_cnt_n;
      byte_idx   <= byte_idx_n;
      word       <= word_n;
      data_out   <= data_n;
      valid_out  <= valid_n;
      active_out <= active_n;
      err_out    <= err_n;
    end
  end
  always_comb begin
    state_n    = state;
    bit_cnt_n  = state == SEARCH ? 3'd0 : bit_cnt + 3'd1;
    idle_cnt_n = idle_cnt;
    byte_idx_n = byte_idx;
    word_n     = word;
    data_n     = data_out;
    valid_n    = 1'b0;
    active_n   = active_out;
    err_n      = 1'b0;
    case (state)
      SEARCH: if (is_idle) begin
        idle_cnt_n = 4'd1;
        state_n    = ALIGN;
      end
      ALIGN: if (byte_done) begin
        if (is_idle) begin
          idle_cnt_n = idle_cnt + 4'd1;
          if (idle_cnt_n == 4'(ALIGN_COUNT)) begin
            state_n  = ACTIVE;
            active_n = 1'b1;
          end
        end else begin
          err_n      = 1'b1;
          idle_cnt_n = 4'd0;
          state_n    = SEARCH;
        end
      end
      // an idle char only counts as filler when it would start a word
      ACTIVE: if (byte_done && !(byte_idx == 2'd0 && is_idle)) begin
        byte_idx_n = byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    word_n[23:16] = cur_byte;
          2'd1:    word_n[15:8]  = cur_byte;
          2'd2:    word_n[7:0]   = cur_byte;
          default: begin
            data_n  = {word, cur_byte};
            valid_n = 1'b1;
          end
        endcase
      end
      default: state_n = SEARCH;
    endcase
  end
endmodule
